fb_axi_read_arbiter: RTL and testbench
======================================

# fb_axi_read_arbiter

Shares the single SRAM AXI read port between two read masters: port 0 is the display pixel stream (latency-critical), port 1 is a general-purpose reader (e.g. CPU or blitter frame-buffer readback). It arbitrates AR requests with display priority plus a bounded-wait guarantee for port 1, and routes R beats back in order using a tag FIFO. It sits directly in front of the SRAM AXI slave, in the AXI clock domain.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 20, address width on all ports
- AXI_DATA_WIDTH, 16, read data width on all ports
- OUTSTANDING, 4, max accepted-but-unanswered reads; power of two, >= 2
- M1_MAX_WAIT, 8, cycles port 1 may be blocked by port 0 before it wins next grant; >= 1

Ports (x = 0, 1):
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- sx_axi_araddr  in  AXI_ADDR_WIDTH  requester x address
- sx_axi_arvalid  in  1  requester x address valid
- sx_axi_arready  out  1  requester x address accepted this cycle
- sx_axi_rdata  out  AXI_DATA_WIDTH  read data (broadcast from master side)
- sx_axi_rresp  out  2  read response (broadcast)
- sx_axi_rvalid  out  1  beat belongs to requester x
- sx_axi_rready  in  1  requester x ready
- m_axi_araddr  out  AXI_ADDR_WIDTH  registered address to SRAM
- m_axi_arvalid  out  1  registered address valid
- m_axi_arready  in  1  SRAM accepts address
- m_axi_rdata  in  AXI_DATA_WIDTH  SRAM read data
- m_axi_rresp  in  2  SRAM response
- m_axi_rvalid  in  1  SRAM data valid
- m_axi_rready  out  1  ready, steered from owning requester

## Operation
- Load slot open: can_load = (!m_axi_arvalid | m_axi_arready) & !tag_full. tag_full counts entries before this cycle's pop (concurrent pop does not open a slot).
- Grant when can_load: if s1_axi_arvalid and wait_cnt == M1_MAX_WAIT -> port 1; else if s0_axi_arvalid -> port 0; else if s1_axi_arvalid -> port 1; else none.
- Granted port sees sx_axi_arready = 1 that cycle (combinational); next edge m_axi_araddr <= its address, m_axi_arvalid <= 1, tag x pushed into tag FIFO.
- No grant and m_axi_arready & m_axi_arvalid -> m_axi_arvalid <= 0; m_axi_araddr holds.
- wait_cnt: +1 (saturating at M1_MAX_WAIT) each cycle s1_axi_arvalid is high and port 1 is not granted; cleared on port-1 grant or when s1_axi_arvalid low.
- R routing: head tag h valid when FIFO non-empty. sh_axi_rvalid = m_axi_rvalid & !empty; other port rvalid = 0. m_axi_rready = !empty & sh_axi_rready. Pop on m_axi_rvalid & m_axi_rready.
- m_axi_rvalid with FIFO empty is a slave protocol error: m_axi_rready = 0, no requester sees rvalid; simulation assertion fires.

## Timing
- Reset (reset low, async): m_axi_arvalid 0, m_axi_araddr 0, tag FIFO empty, wait_cnt 0; consequently both sx_axi_arready 0 only if no load slot, m_axi_rready 0, both sx_axi_rvalid 0. Reset mid-transaction drops all outstanding tags; SRAM side must be reset together.
- AR latency: requester handshake at cycle N -> m_axi_arvalid high at N+1. Sustained 1 grant/cycle when m_axi_arready held high and FIFO not full.
- R path is combinational pass-through (zero latency); data/resp unregistered.
- Response order equals grant order; at most OUTSTANDING tags in flight.

## Structure
- Shared package fb_arb_pkg: typedef of requester tag (1 bit, TAG_DISPLAY = 0, TAG_AUX = 1), AXI resp constants (OKAY = 2'b00).
- Sub-module: tag FIFO as existing `fifo` (DATA_WIDTH 1, DEPTH OUTSTANDING) adapted to async active-low reset, or a local fb_arb_tag_fifo with show-ahead read; arbiter/counter logic stays in top.

## Test plan
- Port 0 only, m_axi_arready = 1, SRAM 2-cycle latency, addrs 0..7 -> m_axi_araddr 0..7 on consecutive cycles, s0 receives 8 beats in order, s1_axi_rvalid never high.
- Both ports continuously valid, M1_MAX_WAIT = 8 -> port 1 granted exactly every 9th grant; wait_cnt never exceeds 8.
- SRAM never returns data -> after 4 grants sx_axi_arready stays 0 and m_axi_arvalid drops after acceptance; first rvalid re-enables one grant the following cycle.
- Interleaved grants 0,1,0 with s1_axi_rready low for 5 cycles at its beat -> m_axi_rready low, SRAM stalled, third beat not delivered to s0 until s1 takes its beat.
- m_axi_arready low for 10 cycles -> m_axi_araddr/arvalid stable, no further arready to requesters.
- reset low mid-burst with 3 outstanding -> next cycle m_axi_arvalid 0, FIFO empty, both sx_axi_rvalid 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// fb_arb_pkg: shared types and constants for the frame-buffer AXI read arbiter.
package fb_arb_pkg;

  // Requester tag carried through the in-flight FIFO
  typedef logic tag_t;

  localparam tag_t TAG_DISPLAY = 1'b0;
  localparam tag_t TAG_AUX     = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/fb_arb_tag_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// fb_arb_tag_fifo: show-ahead FIFO of requester tags for reads in flight.
// data_o is the head entry and is meaningful whenever empty_o is low.
module fb_arb_tag_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  assign data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_axi_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// fb_axi_read_arbiter: shares one SRAM AXI read port between the display stream
// (port 0, priority) and an auxiliary reader (port 1, bounded wait), in-order R routing.
module fb_axi_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int OUTSTANDING    = 4,
  parameter int M1_MAX_WAIT    = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,

  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,

  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int WAIT_W = $clog2(M1_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(M1_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                      arvalid_q, arvalid_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;

  logic can_load;
  logic grant0, grant1, grant;
  tag_t grant_tag, head_tag;
  logic tag_full, tag_empty, tag_pop;
  logic head_rready;

  // A slot opens when the output register is free or draining this cycle;
  // tag_full is evaluated before any concurrent pop.
  always_comb begin
    can_load = (!arvalid_q || m_axi_arready) && !tag_full;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (can_load) begin
      if (s1_axi_arvalid && (wait_q == WAIT_MAX)) begin
        grant1 = 1'b1;
      end else if (s0_axi_arvalid) begin
        grant0 = 1'b1;
      end else if (s1_axi_arvalid) begin
        grant1 = 1'b1;
      end
    end
    grant     = grant0 || grant1;
    grant_tag = grant1 ? TAG_AUX : TAG_DISPLAY;
  end

  assign s0_axi_arready = grant0;
  assign s1_axi_arready = grant1;

  always_comb begin
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    if (grant1) begin
      araddr_d  = s1_axi_araddr;
      arvalid_d = 1'b1;
    end else if (grant0) begin
      araddr_d  = s0_axi_araddr;
      arvalid_d = 1'b1;
    end else if (m_axi_arready) begin
      arvalid_d = 1'b0;
    end
  end

  // Counts every cycle port 1 is left waiting, whether by port 0 or a closed slot
  always_comb begin
    wait_d = '0;
    if (s1_axi_arvalid && !grant1) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : (wait_q + WAIT_ONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      wait_q    <= wait_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;

  fb_arb_tag_fifo #(
    .DATA_WIDTH (1),
    .DEPTH      (OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (grant),
    .data_i  (grant_tag),
    .pop_i   (tag_pop),
    .data_o  (head_tag),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  // Beats are steered purely by the head tag; data and response are broadcast
  always_comb begin
    head_rready   = (head_tag == TAG_AUX) ? s1_axi_rready : s0_axi_rready;
    m_axi_rready  = !tag_empty && head_rready;
    s0_axi_rvalid = m_axi_rvalid && !tag_empty && (head_tag == TAG_DISPLAY);
    s1_axi_rvalid = m_axi_rvalid && !tag_empty && (head_tag == TAG_AUX);
    tag_pop       = m_axi_rvalid && m_axi_rready;
  end

  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;

  a_no_orphan_beat: assert property (@(posedge clk) disable iff (!reset)
    !(m_axi_rvalid && tag_empty));

endmodule
`default_nettype wire

// File: tb/tb_fb_axi_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fb_axi_read_arbiter: scoreboard bench for the frame-buffer AXI read arbiter
// with a behavioural SRAM read slave of configurable latency.
module tb_fb_axi_read_arbiter;
  import fb_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic          s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
  logic          s0_axi_arready, s1_axi_arready, m_axi_arready;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic          s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready, m_axi_rready;

  always #5 clk = ~clk;

  fb_axi_read_arbiter #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .OUTSTANDING    (4),
    .M1_MAX_WAIT    (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rresp   (s0_axi_rresp),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready),
    .s1_axi_araddr  (s1_axi_araddr),
    .s1_axi_arvalid (s1_axi_arvalid),
    .s1_axi_arready (s1_axi_arready),
    .s1_axi_rdata   (s1_axi_rdata),
    .s1_axi_rresp   (s1_axi_rresp),
    .s1_axi_rvalid  (s1_axi_rvalid),
    .s1_axi_rready  (s1_axi_rready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  typedef struct { logic port; logic [AW-1:0] addr; } exp_t;
  typedef struct { logic [AW-1:0] addr; int t; } sram_t;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_ar[$];
  sram_t         sram_q[$];
  logic [AW-1:0] req0[$], req1[$];
  int            glog_cyc[$];
  logic          glog_port[$];
  int            rx_cnt[2];
  int            cyc = 0;
  int            first_pop = 0;
  int            lat = 2;
  bit            sram_en = 1'b1;
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    return (a[1:0] == 2'b11) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

  // Requester drivers, SRAM model and scoreboard; samples on negedge, drives 1ns after posedge
  initial begin : bench_proc
    bit            hs0, hs1, acc, popr, exp_rr, got_v;
    logic [AW-1:0] acc_addr, a;
    logic [DW-1:0] got_d;
    logic [1:0]    got_r;
    int            acc_t;
    exp_t          e;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (s0_axi_rvalid) begin
        n_chk++;
        if (exp_q.size() == 0 || exp_q[0].port !== 1'b0) begin
          n_fail++;
          $display("FAIL route_s0: s0_axi_rvalid=1 with %0d pending, head not port 0", exp_q.size());
        end
      end
      if (s1_axi_rvalid) begin
        n_chk++;
        if (exp_q.size() == 0 || exp_q[0].port !== 1'b1) begin
          n_fail++;
          $display("FAIL route_s1: s1_axi_rvalid=1 with %0d pending, head not port 1", exp_q.size());
        end
      end
      exp_rr = 1'b0;
      if (exp_q.size() != 0) exp_rr = exp_q[0].port ? s1_axi_rready : s0_axi_rready;
      n_chk++;
      if (m_axi_rready !== exp_rr) begin
        n_fail++;
        $display("FAIL m_rready: got %b expected %b (cycle %0d)", m_axi_rready, exp_rr, cyc);
      end
      popr = m_axi_rvalid && m_axi_rready;
      if (popr) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_orphan: beat accepted with no outstanding read (cycle %0d)", cyc);
        end else begin
          e     = exp_q.pop_front();
          got_v = e.port ? s1_axi_rvalid : s0_axi_rvalid;
          got_d = e.port ? s1_axi_rdata : s0_axi_rdata;
          got_r = e.port ? s1_axi_rresp : s0_axi_rresp;
          if (got_v !== 1'b1 || got_d !== data_of(e.addr) || got_r !== resp_of(e.addr)) begin
            n_fail++;
            $display("FAIL beat_p%0d: got v=%b d=%h r=%h expected v=1 d=%h r=%h", e.port,
                     got_v, got_d, got_r, data_of(e.addr), resp_of(e.addr));
          end
          rx_cnt[e.port]++;
          if (first_pop < 0) first_pop = cyc;
        end
      end
      acc = m_axi_arvalid && m_axi_arready;
      if (acc) begin
        n_chk++;
        acc_addr = m_axi_araddr;
        acc_t    = cyc;
        if (exp_ar.size() == 0) begin
          n_fail++;
          $display("FAIL ar_orphan: m_axi_araddr %h accepted with no grant", m_axi_araddr);
        end else begin
          a = exp_ar.pop_front();
          if (m_axi_araddr !== a) begin
            n_fail++;
            $display("FAIL ar_addr: got %h expected %h", m_axi_araddr, a);
          end
        end
      end
      hs0 = s0_axi_arvalid && s0_axi_arready;
      hs1 = s1_axi_arvalid && s1_axi_arready;
      if (hs0 && hs1) begin
        n_chk++;
        n_fail++;
        $display("FAIL double_grant: both ports granted in cycle %0d", cyc);
      end
      if (hs0) begin
        exp_q.push_back('{1'b0, s0_axi_araddr});
        exp_ar.push_back(s0_axi_araddr);
        glog_port.push_back(1'b0);
        glog_cyc.push_back(cyc);
      end
      if (hs1) begin
        exp_q.push_back('{1'b1, s1_axi_araddr});
        exp_ar.push_back(s1_axi_araddr);
        glog_port.push_back(1'b1);
        glog_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (hs0 && req0.size() != 0) void'(req0.pop_front());
      if (hs1 && req1.size() != 0) void'(req1.pop_front());
      s0_axi_arvalid = (req0.size() != 0);
      s0_axi_araddr  = (req0.size() != 0) ? req0[0] : '0;
      s1_axi_arvalid = (req1.size() != 0);
      s1_axi_araddr  = (req1.size() != 0) ? req1[0] : '0;
      if (popr && sram_q.size() != 0) void'(sram_q.pop_front());
      if (acc) sram_q.push_back('{acc_addr, acc_t});
      m_axi_rvalid = sram_en && (sram_q.size() != 0) && (cyc >= sram_q[0].t + lat);
      m_axi_rdata  = (sram_q.size() != 0) ? data_of(sram_q[0].addr) : '0;
      m_axi_rresp  = (sram_q.size() != 0) ? resp_of(sram_q[0].addr) : AXI_RESP_OKAY;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k = 0;
    while ((req0.size() != 0 || req1.size() != 0 || exp_q.size() != 0 || sram_q.size() != 0)
           && k < budget) begin
      tick();
      k++;
    end
    n_chk++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: busy after %0d cycles (req0=%0d req1=%0d pending=%0d)",
               nm, budget, req0.size(), req1.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s0_axi_arvalid = 1'b0; s0_axi_araddr = '0; s0_axi_rready = 1'b1;
    s1_axi_arvalid = 1'b0; s1_axi_araddr = '0; s1_axi_rready = 1'b1;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", m_axi_arvalid); end
    n_chk++;
    if (m_axi_araddr !== '0) begin n_fail++; $display("FAIL reset_araddr: got %h expected 0", m_axi_araddr); end
    n_chk++;
    if (m_axi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", m_axi_rready); end
    n_chk++;
    if ({s1_axi_rvalid, s0_axi_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {s1_axi_rvalid, s0_axi_rvalid});
    end
    n_chk++;
    if ({s1_axi_arready, s0_axi_arready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_arready: got %b expected 00", {s1_axi_arready, s0_axi_arready});
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_port0_stream();
    int g0 = glog_cyc.size();
    int r0 = rx_cnt[0];
    int r1 = rx_cnt[1];
    lat = 2;
    for (int i = 0; i < 8; i++) req0.push_back(AW'(i));
    wait_drain("stream", 100);
    n_chk++;
    if (glog_cyc.size() - g0 != 8) begin
      n_fail++; $display("FAIL stream_grants: got %0d expected 8", glog_cyc.size() - g0);
    end else begin
      for (int i = 1; i < 8; i++) begin
        n_chk++;
        if (glog_cyc[g0+i] != glog_cyc[g0] + i || glog_port[g0+i] !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_b2b: grant %0d at cycle %0d port %b expected cycle %0d port 0",
                   i, glog_cyc[g0+i], glog_port[g0+i], glog_cyc[g0] + i);
        end
      end
    end
    n_chk++;
    if (rx_cnt[0] - r0 != 8 || rx_cnt[1] - r1 != 0) begin
      n_fail++; $display("FAIL stream_beats: got s0=%0d s1=%0d expected s0=8 s1=0", rx_cnt[0] - r0, rx_cnt[1] - r1);
    end
  endtask

  task automatic test_wait_bound();
    int g0 = glog_cyc.size();
    bit want;
    for (int i = 0; i < 30; i++) req0.push_back(AW'(32'h1000 + i));
    for (int i = 0; i < 3; i++) req1.push_back(AW'(32'h2000 + i));
    wait_drain("wait_bound", 300);
    n_chk++;
    if (glog_cyc.size() - g0 != 33) begin
      n_fail++; $display("FAIL wait_grants: got %0d expected 33", glog_cyc.size() - g0);
    end else begin
      for (int i = 0; i < 27; i++) begin
        want = ((i % 9) == 8);
        n_chk++;
        if (glog_port[g0+i] !== want || glog_cyc[g0+i] != glog_cyc[g0] + i) begin
          n_fail++;
          $display("FAIL wait_order: grant %0d port %b cycle %0d expected port %b cycle %0d",
                   i, glog_port[g0+i], glog_cyc[g0+i], want, glog_cyc[g0] + i);
        end
      end
    end
  endtask

  task automatic test_no_response();
    int g0 = glog_cyc.size();
    int k = 0;
    sram_en = 1'b0;
    first_pop = -1;
    for (int i = 0; i < 6; i++) req0.push_back(AW'(32'h100 + i));
    repeat (12) tick();
    n_chk++;
    if (glog_cyc.size() - g0 != 4) begin
      n_fail++; $display("FAIL nors_grants: got %0d expected 4", glog_cyc.size() - g0);
    end
    @(negedge clk);
    n_chk++;
    if (s0_axi_arvalid !== 1'b1 || s0_axi_arready !== 1'b0) begin
      n_fail++; $display("FAIL nors_arready: got arvalid=%b arready=%b expected 1/0", s0_axi_arvalid, s0_axi_arready);
    end
    n_chk++;
    if (m_axi_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL nors_arvalid: got %b expected 0", m_axi_arvalid);
    end
    tick();
    sram_en = 1'b1;
    while (glog_cyc.size() - g0 < 5 && k < 20) begin tick(); k++; end
    n_chk++;
    if (glog_cyc.size() - g0 < 5) begin
      n_fail++; $display("FAIL nors_resume: got %0d grants expected 5", glog_cyc.size() - g0);
    end else if (glog_cyc[g0+4] != first_pop + 1) begin
      n_fail++; $display("FAIL nors_resume: grant at cycle %0d expected %0d", glog_cyc[g0+4], first_pop + 1);
    end
    wait_drain("nors", 100);
  endtask

  task automatic test_rready_stall();
    int k = 0;
    int r0, r1;
    s1_axi_rready = 1'b0;
    req0.push_back(AW'(32'h200));
    while (req0.size() != 0 && k < 20) begin tick(); k++; end
    req1.push_back(AW'(32'h201));
    while (req1.size() != 0 && k < 40) begin tick(); k++; end
    req0.push_back(AW'(32'h202));
    while (req0.size() != 0 && k < 60) begin tick(); k++; end
    n_chk++;
    if (k >= 60) begin n_fail++; $display("FAIL stall_issue: requests not granted within %0d cycles", k); end
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      if (s1_axi_rvalid) break;
      k++;
    end
    n_chk++;
    if (k >= 30) begin n_fail++; $display("FAIL stall_s1_beat: s1_axi_rvalid not seen in 30 cycles"); end
    r0 = rx_cnt[0];
    r1 = rx_cnt[1];
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (m_axi_rready !== 1'b0 || s1_axi_rvalid !== 1'b1 || s0_axi_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got rready=%b s1_rvalid=%b s0_rvalid=%b expected 0/1/0",
                 i, m_axi_rready, s1_axi_rvalid, s0_axi_rvalid);
      end
      @(negedge clk);
    end
    tick();
    n_chk++;
    if (rx_cnt[0] != r0 || rx_cnt[1] != r1) begin
      n_fail++; $display("FAIL stall_nobeat: beats delivered during stall s0=%0d s1=%0d", rx_cnt[0] - r0, rx_cnt[1] - r1);
    end
    s1_axi_rready = 1'b1;
    wait_drain("stall", 50);
    n_chk++;
    if (rx_cnt[0] != r0 + 1 || rx_cnt[1] != r1 + 1) begin
      n_fail++; $display("FAIL stall_release: got s0=%0d s1=%0d expected 1/1", rx_cnt[0] - r0, rx_cnt[1] - r1);
    end
  endtask

  task automatic test_arready_stall();
    int g0 = glog_cyc.size();
    int k = 0;
    m_axi_arready = 1'b0;
    for (int i = 0; i < 3; i++) req0.push_back(AW'(32'h300 + i));
    while (glog_cyc.size() == g0 && k < 20) begin tick(); k++; end
    n_chk++;
    if (glog_cyc.size() == g0) begin n_fail++; $display("FAIL arst_first: no grant within 20 cycles"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== AW'(32'h300) || s0_axi_arready !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_hold: cycle %0d got arvalid=%b araddr=%h arready=%b expected 1/00300/0",
                 i, m_axi_arvalid, m_axi_araddr, s0_axi_arready);
      end
    end
    tick();
    m_axi_arready = 1'b1;
    wait_drain("arst", 50);
  endtask

  task automatic test_reset_mid();
    int g0 = glog_cyc.size();
    int k = 0;
    int r0, r1;
    lat = 20;
    for (int i = 0; i < 3; i++) req0.push_back(AW'(32'h400 + i));
    while (glog_cyc.size() - g0 < 3 && k < 20) begin tick(); k++; end
    tick();
    tick();
    n_chk++;
    if (exp_q.size() != 3) begin n_fail++; $display("FAIL rstmid_setup: got %0d outstanding expected 3", exp_q.size()); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    req0.delete(); req1.delete(); exp_q.delete(); exp_ar.delete(); sram_q.delete();
    s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0;
    tick();
    @(negedge clk);
    n_chk++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || {s1_axi_rvalid, s0_axi_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_state: got arvalid=%b rready=%b rvalid=%b%b expected 0/0/00",
               m_axi_arvalid, m_axi_rready, s1_axi_rvalid, s0_axi_rvalid);
    end
    tick();
    reset = 1'b1;
    lat = 2;
    r0 = rx_cnt[0];
    r1 = rx_cnt[1];
    req1.push_back(AW'(32'h500));
    req1.push_back(AW'(32'h503));
    wait_drain("rstmid", 50);
    n_chk++;
    if (rx_cnt[1] != r1 + 2 || rx_cnt[0] != r0) begin
      n_fail++; $display("FAIL rstmid_fresh: got s0=%0d s1=%0d expected 0/2", rx_cnt[0] - r0, rx_cnt[1] - r1);
    end
  endtask

  initial begin : main
    test_reset();
    test_port0_stream();
    test_wait_bound();
    test_no_response();
    test_rready_stall();
    test_arready_stall();
    test_reset_mid();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
